// File: rtl/regfile_sweep_if.sv
// rtl/regfile_sweep_if.sv - register file operand/result bus bundle
//   master: decoder/ALU side drives selects, write data, DIN and CLR_REQ
//   slave : register file drives ABUS, BBUS, BUSY and WR_DROP
interface regfile_sweep_if #(
    parameter int WIDTH = 16,
    parameter int SELW  = 3
);
    logic [SELW-1:0]  ASEL;
    logic [SELW-1:0]  BSEL;
    logic [SELW-1:0]  DSEL;
    logic             WE;
    logic [WIDTH-1:0] RIN;
    logic [WIDTH-1:0] DIN;
    logic             CLR_REQ;
    logic [WIDTH-1:0] ABUS;
    logic [WIDTH-1:0] BBUS;
    logic             BUSY;
    logic             WR_DROP;

    modport master (
        output ASEL, BSEL, DSEL, WE, RIN, DIN, CLR_REQ,
        input  ABUS, BBUS, BUSY, WR_DROP
    );

    modport slave (
        input  ASEL, BSEL, DSEL, WE, RIN, DIN, CLR_REQ,
        output ABUS, BBUS, BUSY, WR_DROP
    );
endinterface

// File: rtl/regfile_sweep.sv
// rtl/regfile_sweep.sv - register file with bypassed select 0 and sequential sweep clear
//   CLK : clock, all state updates on rising edge
//   RST : synchronous active-low reset
//   bus : regfile_sweep_if.slave
//         ASEL/BSEL : read selects (0 selects DIN)
//         DSEL/WE/RIN : write port (DSEL 0 is no write)
//         CLR_REQ : start a sweep clearing R[1..NREG], one register per cycle
//         ABUS/BBUS : combinational read data
//         BUSY : sweep in progress
//         WR_DROP : one-cycle pulse after a write discarded during a sweep
//   Optional macro REGFILE_WR_BYPASS_EN: same-cycle write data forwarded to
//   the read buses while idle.
module regfile_sweep #(
    parameter int WIDTH = 16,
    parameter int SELW  = 3
) (
    input  logic           CLK,
    input  logic           RST,
    regfile_sweep_if.slave bus
);
    localparam int NREG = (2 ** SELW) - 1;
    localparam logic [SELW-1:0] LAST_PTR = SELW'(NREG);

    typedef enum logic {IDLE, SWEEP} state_t;

    // Entry 0 is never written; it only keeps the index space a full power of two.
    logic [WIDTH-1:0] r_regs [0:NREG];
    state_t           r_state;
    logic [SELW-1:0]  r_ptr;
    logic             r_busy;
    logic             r_wr_drop;

    logic             w_wr_req;
    logic [WIDTH-1:0] w_abus;
    logic [WIDTH-1:0] w_bbus;

    assign w_wr_req = bus.WE && (bus.DSEL != '0);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i <= NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_busy    <= 1'b0;
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A write accepted together with CLR_REQ lands now and
                    // is zeroed later by the sweep it started.
                    if (w_wr_req) begin
                        r_regs[bus.DSEL] <= bus.RIN;
                    end
                    if (bus.CLR_REQ) begin
                        r_state <= SWEEP;
                        r_ptr   <= SELW'(1);
                        r_busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    r_regs[r_ptr] <= '0;
                    if (w_wr_req) begin
                        r_wr_drop <= 1'b1;
                    end
                    // Terminal compare against NREG keeps PTR from wrapping to 0.
                    if (r_ptr == LAST_PTR) begin
                        r_state <= IDLE;
                        r_ptr   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ptr <= r_ptr + SELW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ptr   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_abus = (bus.ASEL == '0) ? bus.DIN : r_regs[bus.ASEL];
        w_bbus = (bus.BSEL == '0) ? bus.DIN : r_regs[bus.BSEL];
`ifdef REGFILE_WR_BYPASS_EN
        // No forwarding while sweeping: that write is going to be dropped.
        if (w_wr_req && !r_busy && (bus.ASEL == bus.DSEL)) begin
            w_abus = bus.RIN;
        end
        if (w_wr_req && !r_busy && (bus.BSEL == bus.DSEL)) begin
            w_bbus = bus.RIN;
        end
`endif
    end

    assign bus.ABUS    = w_abus;
    assign bus.BBUS    = w_bbus;
    assign bus.BUSY    = r_busy;
    assign bus.WR_DROP = r_wr_drop;
endmodule

// File: tb/tb_regfile_sweep.sv
// tb/tb_regfile_sweep.sv - self-checking bench for regfile_sweep
`timescale 1ns/1ps
module tb_regfile_sweep;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    regfile_sweep_if #(.WIDTH(16), .SELW(3)) rf ();

    regfile_sweep #(.WIDTH(16), .SELW(3)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (rf)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    typedef struct {
        logic [2:0]  asel;
        logic [2:0]  bsel;
        logic [2:0]  dsel;
        logic        we;
        logic [15:0] rin;
        logic [15:0] din;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        ebusy;
        logic        edrop;
    } vec_t;

    vec_t vecs [7];
    vec_t exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic read_reg(input logic [2:0] k, output logic [15:0] v);
        rf.ASEL = k;
        #1;
        v = rf.ABUS;
    endtask

    function automatic vec_t mk(input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
                                input logic we, input logic [15:0] rin, input logic [15:0] din,
                                input logic [15:0] ea, input logic [15:0] eb);
        vec_t v;
        v.asel = a; v.bsel = b; v.dsel = d; v.we = we; v.rin = rin; v.din = din;
        v.ea = ea; v.eb = eb; v.ebusy = 1'b0; v.edrop = 1'b0;
        return v;
    endfunction

    logic [15:0] rd;
    int          cnt;
    int          waited;

    initial begin
        n_chk = 0;
        n_fail = 0;
        rf.ASEL = '0; rf.BSEL = '0; rf.DSEL = '0; rf.WE = 1'b0;
        rf.RIN = '0; rf.DIN = '0; rf.CLR_REQ = 1'b0;
        rst = 1'b0;

        vecs[0] = mk(3'd0, 3'd5, 3'd0, 1'b0, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h0000);
`ifdef REGFILE_WR_BYPASS_EN
        vecs[1] = mk(3'd3, 3'd0, 3'd3, 1'b1, 16'h1234, 16'h0000, 16'h1234, 16'h0000);
        vecs[4] = mk(3'd4, 3'd0, 3'd4, 1'b1, 16'h0001, 16'h00C3, 16'h0001, 16'h00C3);
        vecs[5] = mk(3'd4, 3'd4, 3'd4, 1'b1, 16'hA5A5, 16'h0000, 16'hA5A5, 16'hA5A5);
`else
        vecs[1] = mk(3'd3, 3'd0, 3'd3, 1'b1, 16'h1234, 16'h0000, 16'h0000, 16'h0000);
        vecs[4] = mk(3'd4, 3'd0, 3'd4, 1'b1, 16'h0001, 16'h00C3, 16'h0000, 16'h00C3);
        vecs[5] = mk(3'd4, 3'd4, 3'd4, 1'b1, 16'hA5A5, 16'h0000, 16'h0001, 16'h0001);
`endif
        vecs[2] = mk(3'd3, 3'd3, 3'd0, 1'b1, 16'hFFFF, 16'h0000, 16'h1234, 16'h1234);
        vecs[3] = mk(3'd3, 3'd1, 3'd0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 16'h0000);
        vecs[6] = mk(3'd4, 3'd3, 3'd0, 1'b0, 16'h0000, 16'h0000, 16'hA5A5, 16'h1234);

        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Table vectors: drive, push expectation, sample mid-cycle, pop and compare.
        for (int i = 0; i < 7; i++) begin
            vec_t e;
            rf.ASEL = vecs[i].asel; rf.BSEL = vecs[i].bsel; rf.DSEL = vecs[i].dsel;
            rf.WE = vecs[i].we; rf.RIN = vecs[i].rin; rf.DIN = vecs[i].din;
            exp_q.push_back(vecs[i]);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("vec%0d_abus", i), {16'h0, rf.ABUS}, {16'h0, e.ea});
            chk($sformatf("vec%0d_bbus", i), {16'h0, rf.BBUS}, {16'h0, e.eb});
            chk($sformatf("vec%0d_busy", i), {31'h0, rf.BUSY}, {31'h0, e.ebusy});
            chk($sformatf("vec%0d_drop", i), {31'h0, rf.WR_DROP}, {31'h0, e.edrop});
            @(negedge clk);
        end
        rf.WE = 1'b0; rf.DSEL = '0; rf.BSEL = '0; rf.DIN = '0;

        // Sweep A: plain sweep with mid-sweep contents check.
        for (int k = 1; k <= 7; k++) begin
            rf.WE = 1'b1; rf.DSEL = 3'(k); rf.RIN = 16'(k * 16'h0011);
            @(negedge clk);
        end
        rf.WE = 1'b0; rf.DSEL = '0;
        read_reg(3'd5, rd); chk("load_r5", {16'h0, rd}, 32'h0055);
        rf.CLR_REQ = 1'b1;
        #1; chk("busy_before_sweep", {31'h0, rf.BUSY}, 32'h0);
        @(negedge clk);
        rf.CLR_REQ = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!rf.BUSY) break;
            cnt++;
            if (cnt == 4) begin
                for (int k = 1; k <= 3; k++) begin
                    read_reg(3'(k), rd); chk($sformatf("midA_r%0d", k), {16'h0, rd}, 32'h0);
                end
                read_reg(3'd4, rd); chk("midA_r4", {16'h0, rd}, 32'h0044);
            end
            @(negedge clk);
        end
        chk("sweepA_len", cnt, 7);
        for (int k = 1; k <= 7; k++) begin
            read_reg(3'(k), rd); chk($sformatf("postA_r%0d", k), {16'h0, rd}, 32'h0);
        end

        // Sweep B: dropped write in 2nd busy cycle, CLR_REQ re-pulse mid-sweep.
        @(negedge clk);
        for (int k = 1; k <= 7; k++) begin
            rf.WE = 1'b1; rf.DSEL = 3'(k); rf.RIN = 16'(k * 16'h0011);
            @(negedge clk);
        end
        rf.WE = 1'b0; rf.DSEL = '0;
        rf.CLR_REQ = 1'b1;
        @(negedge clk);
        rf.CLR_REQ = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!rf.BUSY) break;
            cnt++;
            if (cnt == 2) begin
                chk("dropB_before", {31'h0, rf.WR_DROP}, 32'h0);
                rf.WE = 1'b1; rf.DSEL = 3'd7; rf.RIN = 16'hFFFF;
            end
            if (cnt == 3) begin
                rf.WE = 1'b0; rf.DSEL = '0;
                chk("dropB_pulse", {31'h0, rf.WR_DROP}, 32'h1);
                rf.CLR_REQ = 1'b1;
            end
            if (cnt == 4) begin
                rf.CLR_REQ = 1'b0;
                chk("dropB_after", {31'h0, rf.WR_DROP}, 32'h0);
            end
            @(negedge clk);
        end
        rf.CLR_REQ = 1'b0;
        chk("sweepB_len", cnt, 7);
        read_reg(3'd7, rd); chk("postB_r7", {16'h0, rd}, 32'h0);

        // Reset in the 4th busy cycle aborts the sweep and clears everything.
        @(negedge clk);
        for (int k = 1; k <= 7; k++) begin
            rf.WE = 1'b1; rf.DSEL = 3'(k); rf.RIN = 16'(k * 16'h0011);
            @(negedge clk);
        end
        rf.WE = 1'b0; rf.DSEL = '0;
        rf.CLR_REQ = 1'b1;
        @(negedge clk);
        rf.CLR_REQ = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!rf.BUSY) break;
            cnt++;
            if (cnt == 4) begin
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                #1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_mid_cnt", cnt, 4);
        chk("rst_mid_busy", {31'h0, rf.BUSY}, 32'h0);
        chk("rst_mid_drop", {31'h0, rf.WR_DROP}, 32'h0);
        for (int k = 1; k <= 7; k++) begin
            read_reg(3'(k), rd); chk($sformatf("rst_mid_r%0d", k), {16'h0, rd}, 32'h0);
        end

        // Write and CLR_REQ in the same idle cycle.
        @(negedge clk);
        rf.WE = 1'b1; rf.DSEL = 3'd2; rf.RIN = 16'h0BAD; rf.CLR_REQ = 1'b1;
        @(negedge clk);
        rf.WE = 1'b0; rf.DSEL = '0; rf.CLR_REQ = 1'b0;
        read_reg(3'd2, rd); chk("clrwr_r2_written", {16'h0, rd}, 32'h0BAD);
        chk("clrwr_busy", {31'h0, rf.BUSY}, 32'h1);
        chk("clrwr_nodrop", {31'h0, rf.WR_DROP}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        read_reg(3'd2, rd); chk("clrwr_r2_swept", {16'h0, rd}, 32'h0);
        waited = 0;
        while (rf.BUSY && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("clrwr_busy_falls", {31'h0, rf.BUSY}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
